reg_apb_bridge: RTL and testbench

//  APB3 slave that turns host register accesses into the internal register-bus strobes (wr_en/rd_en/addr/write_data).

---
 rtl/reg_pkg.sv | 25 ++
 rtl/reg_rdata_mux.sv | 39 +++
 rtl/reg_apb_bridge.sv | 139 +++++++++++++
 tb/tb_reg_apb_bridge.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_pkg
//  Purpose  : Shared register-bus widths, bank indices and bridge FSM states.
//  Revision : 1.0 - initial release
// ============================================================================
package reg_pkg;

    localparam int REG_ADDR_W    = 14;
    localparam int REG_DATA_W    = 16;
    localparam int REG_BANK_LSB  = 8;
    localparam int REG_NUM_BANKS = 8;

    localparam int REG_BANK_TOP  = 0;
    localparam int REG_BANK_CONV = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } reg_bridge_state_t;

endpackage

`default_nettype wire

// File: rtl/reg_rdata_mux.sv
`default_nettype none
// ============================================================================
//  Module   : reg_rdata_mux
//  Purpose  : Combinational bank read-data select on the upper address bits.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_rdata_mux
    import reg_pkg::*;
#(
    parameter int ADDR_W    = REG_ADDR_W,
    parameter int DATA_W    = REG_DATA_W,
    parameter int NUM_BANKS = REG_NUM_BANKS
) (
    input  logic [ADDR_W-1:0]           addr_i,
    input  logic [NUM_BANKS*DATA_W-1:0] bank_rdata_i,
    output logic [DATA_W-1:0]           rdata_o,
    output logic                        mapped_o
);

    localparam int BANK_W = ADDR_W - REG_BANK_LSB;

    logic [BANK_W-1:0] w_bank;
    assign w_bank = addr_i[ADDR_W-1:REG_BANK_LSB];

    // Unmapped banks read as zero with mapped_o low.
    always_comb begin
        rdata_o  = '0;
        mapped_o = 1'b0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (w_bank == BANK_W'(k)) begin
                rdata_o  = bank_rdata_i[k*DATA_W +: DATA_W];
                mapped_o = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/reg_apb_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : reg_apb_bridge
//  Purpose  : APB3 slave to internal register-bus bridge, one wait state.
//             Optional macro REG_SLVERR_EN: unmapped banks get PSLVERR.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_apb_bridge
    import reg_pkg::*;
#(
    parameter int ADDR_W    = REG_ADDR_W,
    parameter int DATA_W    = REG_DATA_W,
    parameter int NUM_BANKS = REG_NUM_BANKS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        psel,
    input  logic                        penable,
    input  logic                        pwrite,
    input  logic [ADDR_W-1:0]           paddr,
    input  logic [DATA_W-1:0]           pwdata,
    output logic                        pready,
    output logic [DATA_W-1:0]           prdata,
    output logic                        pslverr,
    output logic                        wr_en,
    output logic                        rd_en,
    output logic [ADDR_W-1:0]           addr,
    output logic [DATA_W-1:0]           write_data,
    input  logic [NUM_BANKS*DATA_W-1:0] bank_rdata
);

    reg_bridge_state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic              write_q, write_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;

    logic [DATA_W-1:0] w_rdata;
    logic              w_mapped;
    logic              w_setup_ok;
    logic              w_slverr;

    reg_rdata_mux #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NUM_BANKS (NUM_BANKS)
    ) u_rdata_mux (
        .addr_i       (addr_q),
        .bank_rdata_i (bank_rdata),
        .rdata_o      (w_rdata),
        .mapped_o     (w_mapped)
    );

`ifdef REG_SLVERR_EN
    // Decide at SETUP so an unmapped access never strobes a regfile.
    assign w_setup_ok = (int'(paddr[ADDR_W-1:REG_BANK_LSB]) < NUM_BANKS);
    assign w_slverr   = !w_mapped;
`else
    assign w_setup_ok = 1'b1;
    assign w_slverr   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        prdata_d  = prdata_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    addr_d  = paddr;
                    wdata_d = pwdata;
                    write_d = pwrite;
                    wr_en_d = pwrite && w_setup_ok;
                    rd_en_d = !pwrite && w_setup_ok;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                end else begin
                    if (!write_q) begin
                        prdata_d = w_mapped ? w_rdata : '0;
                    end
                    pready_d  = 1'b1;
                    pslverr_d = w_slverr;
                    state_d   = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            prdata_q  <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            prdata_q  <= prdata_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign pready     = pready_q;
    assign prdata     = prdata_q;
    assign pslverr    = pslverr_q;
    assign wr_en      = wr_en_q;
    assign rd_en      = rd_en_q;
    assign addr       = addr_q;
    assign write_data = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_apb_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_apb_bridge
//  Purpose  : Scoreboarded random/directed bench for reg_apb_bridge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_apb_bridge;

    localparam int AW = 14;
    localparam int DW = 16;
    localparam int NB = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           psel = 1'b0;
    logic           penable = 1'b0;
    logic           pwrite = 1'b0;
    logic [AW-1:0]  paddr = '0;
    logic [DW-1:0]  pwdata = '0;
    logic           pready;
    logic [DW-1:0]  prdata;
    logic           pslverr;
    logic           wr_en;
    logic           rd_en;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  write_data;
    logic [NB*DW-1:0] bank_rdata;

    reg_apb_bridge #(.ADDR_W(AW), .DATA_W(DW), .NUM_BANKS(NB)) dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready(pready), .prdata(prdata),
        .pslverr(pslverr), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .write_data(write_data), .bank_rdata(bank_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // Register contents a bank holds out of reset.
    function automatic logic [15:0] init_val(input int a);
        if (a == 'h115) return 16'h0001;
        return 16'(a * 3) ^ 16'h1234;
    endfunction

    // Environment regfiles: write at the clock edge closing a wr_en cycle.
    logic [15:0] mem [0:NB-1][0:255];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NB; k++)
                for (int i = 0; i < 256; i++)
                    mem[k][i] <= init_val(k * 256 + i);
        end else if (wr_en && (int'(addr[13:8]) < NB)) begin
            mem[addr[13:8]][addr[7:0]] <= write_data;
        end
    end
    always_comb begin
        bank_rdata = '0;
        for (int k = 0; k < NB; k++) bank_rdata[k*DW +: DW] = mem[k][addr[7:0]];
    end

    // Reference model: sparse register map plus the last read result.
    logic [15:0] ref_mem [int];
    logic [15:0] last_prd = '0;

    function automatic logic [15:0] ref_read(input int a);
        if ((a >> 8) >= NB) return 16'h0;
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_val(a);
    endfunction

    typedef struct { bit wr; bit rd; logic [AW-1:0] a; logic [DW-1:0] d; } strobe_t;
    typedef struct { logic [DW-1:0] prd; bit err; } resp_t;
    strobe_t sq[$];
    resp_t   rq[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en || rd_en) begin
                if (sq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL strobe_unexpected actual wr=%0b rd=%0b addr=0x%0h required none",
                             wr_en, rd_en, addr);
                end else begin
                    strobe_t s;
                    s = sq.pop_front();
                    chk("strobe_kind", {30'd0, wr_en, rd_en}, {30'd0, s.wr, s.rd});
                    chk("strobe_addr", 32'(addr), 32'(s.a));
                    if (s.wr) chk("strobe_wdata", 32'(write_data), 32'(s.d));
                end
            end
            if (pready) begin
                if (rq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL pready_unexpected actual=1 required=0");
                end else begin
                    resp_t r;
                    r = rq.pop_front();
                    chk("resp_prdata", 32'(prdata), 32'(r.prd));
                    chk("resp_pslverr", 32'(pslverr), 32'(r.err));
                end
            end
        end
    end

    int last_strobe_cyc = 0;

    task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit abort);
        bit mapped;
        bit strobe;
        resp_t r;
        strobe_t s;
        mapped = (int'(a[13:8]) < NB);
        strobe = 1'b1;
`ifdef REG_SLVERR_EN
        strobe = mapped;
`endif
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        if (strobe) begin
            s.wr = wr; s.rd = !wr; s.a = a; s.d = d;
            sq.push_back(s);
            if (wr && mapped) ref_mem[int'(a)] = d;
        end
        @(posedge clk); #1;
        chk("strobe_timing", 32'(wr_en | rd_en), 32'(strobe));
        last_strobe_cyc = cyc;
        if (abort) begin
            psel = 1'b0; penable = 1'b0;
            repeat (3) @(posedge clk);
            #1 chk("abort_no_pready", 32'(pready), 32'd0);
            return;
        end
        penable = 1'b1;
        if (!wr) last_prd = ref_read(int'(a));
        r.prd = last_prd;
        r.err = 1'b0;
`ifdef REG_SLVERR_EN
        r.err = !mapped;
`endif
        rq.push_back(r);
        @(posedge clk); #1;
        chk("pready_timing", 32'(pready), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            psel = 1'b0; penable = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int s1;
        int s2;
        logic [5:0] banks [10];
        banks = '{6'd0, 6'd1, 6'd2, 6'd7, 6'd1, 6'd1, 6'd3, 6'd5, 6'd63, 6'd9};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_outputs", {pready, pslverr, wr_en, rd_en, prdata, 12'd0},
            32'd0);
        chk("reset_addr", {addr, write_data, 2'd0}, 32'd0);

        // Reset asserted while a read strobe is live.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 14'h115;
        @(posedge clk); #1;
        chk("rst_pre_strobe", 32'(rd_en), 32'd1);
        penable = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_strobes", {30'd0, wr_en, rd_en}, 32'd0);
        chk("rst_mid_resp", {15'd0, pready, pslverr, prdata[14:0]}, 32'd0);
        chk("rst_mid_prdata_msb", 32'(prdata[15]), 32'd0);
        chk("rst_mid_addr", {addr, write_data, 2'd0}, 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        xfer(1'b0, 14'h115, 16'h0, 1'b0);
        idle(1);
        xfer(1'b1, 14'h101, 16'h00A5, 1'b0);
        idle(2);
        xfer(1'b0, 14'h101, 16'h0, 1'b0);
        idle(1);

        xfer(1'b1, 14'h108, 16'h0203, 1'b0);
        s1 = last_strobe_cyc;
        xfer(1'b0, 14'h108, 16'h0, 1'b0);
        s2 = last_strobe_cyc;
        chk("b2b_strobe_spacing", 32'(s2 - s1), 32'd3);
        idle(1);

        xfer(1'b0, 14'h3F00, 16'h0, 1'b0);
        xfer(1'b1, 14'h3F00, 16'h7777, 1'b0);
        idle(1);

        xfer(1'b1, 14'h120, 16'hBEEF, 1'b1);
        idle(1);
        xfer(1'b0, 14'h120, 16'h0, 1'b0);
        idle(1);

        for (int i = 0; i < 80; i++) begin
            logic [5:0] b;
            logic [AW-1:0] a;
            b = banks[$urandom_range(0, 9)];
            a = {b, 8'($urandom_range(0, 7))};
            xfer(1'($urandom_range(0, 1)), a, 16'($urandom), ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(3);

        chk("strobe_queue_empty", 32'(sq.size()), 32'd0);
        chk("resp_queue_empty", 32'(rq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
